// File: rtl/ads8864_pkg.sv
// Shared state encoding, default timing parameters and width helpers for the ADS8864 controller.
package ads8864_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_SCLK_DIV     = 2;
  localparam int DEF_CNV_HIGH     = 140;
  localparam int DEF_DATA_BITS    = 16;
  localparam int DEF_BUSY_TIMEOUT = 200;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter holding 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ads8864_sclk_gen.sv
// ADC serial clock: SCLK_DIV cycles low then SCLK_DIV high while enabled, idle low otherwise.
// sample is high in the last high-phase cycle, so the consumer captures data on the edge where SCLK falls.
module ads8864_sclk_gen
  import ads8864_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic sample
);

  localparam int PERIOD = 2 * SCLK_DIV;
  localparam int PW     = cnt_width(PERIOD);

  logic [PW-1:0] phase;

  assign sample = en && (phase == PW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else if (phase == PW'(PERIOD - 1)) begin
      phase <= '0;
      sclk  <= 1'b0;
    end else begin
      phase <= phase + PW'(1);
      sclk  <= (phase + PW'(1)) >= PW'(SCLK_DIV);
    end
  end

endmodule

// File: rtl/ads8864_ctrl.sv
// ADS8864 conversion sequencer: CNVST pulse, DATA_BITS-bit serial read, DATA_VALID 1+CNV_HIGH+2*SCLK_DIV*DATA_BITS cycles after START.
// Define ADS8864_BUSY_IND_EN to end CONV on the ADC busy indicator (synchronized SDOUT low) with a BUSY_TIMEOUT error exit.
module ads8864_ctrl
  import ads8864_pkg::*;
#(
  parameter int SCLK_DIV     = DEF_SCLK_DIV,
  parameter int CNV_HIGH     = DEF_CNV_HIGH,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                 SYSCLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 CONT,
  output logic                 AD_CNVST,
  output logic                 AD_SCLK,
  input  logic                 AD_SDOUT,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_VALID,
  output logic                 BUSY,
  output logic                 ERR
);

  // One counter serves both the fixed CNVST width and the busy timeout.
  localparam int CW = cnt_width(max2(CNV_HIGH, BUSY_TIMEOUT));
  localparam int BW = cnt_width(DATA_BITS);

  state_t               state;
  logic [CW-1:0]        cnv_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 read_en;
  logic                 sample;

  assign read_en = (state == S_READ);

  ads8864_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk   (SYSCLK),
    .rst   (RESET),
    .en    (read_en),
    .sclk  (AD_SCLK),
    .sample(sample)
  );

`ifdef ADS8864_BUSY_IND_EN
  logic [1:0] busy_sync;
  logic       err;

  // Resets to "busy" so a START right after reset cannot see a stale low.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) busy_sync <= 2'b11;
    else       busy_sync <= {busy_sync[0], AD_SDOUT};
  end

  assign ERR = err;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      AD_CNVST   <= 1'b0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      cnv_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef ADS8864_BUSY_IND_EN
      err        <= 1'b0;
`endif
    end else begin
      DATA_VALID <= 1'b0;
`ifdef ADS8864_BUSY_IND_EN
      err        <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (START || CONT) begin
            state    <= S_CONV;
            AD_CNVST <= 1'b1;
            BUSY     <= 1'b1;
            cnv_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        S_CONV: begin
`ifdef ADS8864_BUSY_IND_EN
          if (!busy_sync[1]) begin
            state    <= S_READ;
            AD_CNVST <= 1'b0;
          end else if (cnv_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            state    <= S_IDLE;
            AD_CNVST <= 1'b0;
            BUSY     <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnv_cnt <= cnv_cnt + CW'(1);
          end
`else
          if (cnv_cnt == CW'(CNV_HIGH - 1)) begin
            state    <= S_READ;
            AD_CNVST <= 1'b0;
          end else begin
            cnv_cnt <= cnv_cnt + CW'(1);
          end
`endif
        end
        S_READ: begin
          if (sample) begin
            shreg <= {shreg[DATA_BITS-2:0], AD_SDOUT};
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= S_DONE;
            else                               bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_DONE: begin
          DATA       <= shreg;
          DATA_VALID <= 1'b1;
          if (CONT) begin
            state    <= S_CONV;
            AD_CNVST <= 1'b1;
            cnv_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          AD_CNVST <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads8864_ctrl.sv
// Directed-plus-random bench for ads8864_ctrl (default build) with a behavioural ADC and timing model.
module tb_ads8864_ctrl;

  localparam int DIV  = 2;
  localparam int CNVH = 140;
  localparam int DB   = 16;
  localparam int BTO  = 200;
  localparam int LAT  = 1 + CNVH + 2 * DIV * DB;

  logic          SYSCLK = 1'b0;
  logic          RESET;
  logic          START;
  logic          CONT;
  logic          AD_CNVST;
  logic          AD_SCLK;
  logic          AD_SDOUT;
  logic [DB-1:0] DATA;
  logic          DATA_VALID;
  logic          BUSY;
  logic          ERR;

  ads8864_ctrl #(
    .SCLK_DIV    (DIV),
    .CNV_HIGH    (CNVH),
    .DATA_BITS   (DB),
    .BUSY_TIMEOUT(BTO)
  ) dut (
    .SYSCLK    (SYSCLK),
    .RESET     (RESET),
    .START     (START),
    .CONT      (CONT),
    .AD_CNVST  (AD_CNVST),
    .AD_SCLK   (AD_SCLK),
    .AD_SDOUT  (AD_SDOUT),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial forever #5 SYSCLK = ~SYSCLK;
  initial forever begin
    @(posedge SYSCLK);
    cyc++;
  end

  // ADC model: present MSB on CNVST rise, next bit after each SCLK fall.
  logic [DB-1:0] pat_q[$];
  logic [DB-1:0] cur_word = '0;
  int            nfall    = 0;
  initial begin
    AD_SDOUT = 1'b0;
    forever begin
      @(negedge AD_SCLK or posedge AD_CNVST);
      if (AD_CNVST === 1'b1) begin
        cur_word = (pat_q.size() > 0) ? pat_q.pop_front() : '0;
        nfall    = 0;
      end else begin
        nfall++;
      end
      AD_SDOUT = (nfall < DB) ? cur_word[DB-1-nfall] : 1'b0;
    end
  end

  // Observation log sampled on falling edges.
  int            n_cnv = 0, n_sclk = 0, run = 0, last_run = 0, n_dv_long = 0, hold_err = 0;
  int            dv_cyc_q[$];
  logic [DB-1:0] dv_dat_q[$];
  logic          p_cnv = 1'b0, p_sclk = 1'b0, p_dv = 1'b0;
  logic [DB-1:0] p_data = '0;
  bit            hold_chk_en = 1'b1;
  initial forever begin
    @(negedge SYSCLK);
    if (AD_CNVST === 1'b1 && p_cnv !== 1'b1) n_cnv++;
    if (AD_CNVST === 1'b1) run++;
    else if (p_cnv === 1'b1) begin
      last_run = run;
      run      = 0;
    end
    if (AD_SCLK === 1'b1 && p_sclk !== 1'b1) n_sclk++;
    if (DATA_VALID === 1'b1) begin
      dv_cyc_q.push_back(cyc);
      dv_dat_q.push_back(DATA);
      if (p_dv === 1'b1) n_dv_long++;
    end
    if (hold_chk_en && DATA_VALID !== 1'b1 && DATA !== p_data) hold_err++;
    p_cnv  = AD_CNVST;
    p_sclk = AD_SCLK;
    p_dv   = DATA_VALID;
    p_data = DATA;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(output int n0);
    @(negedge SYSCLK);
    START = 1'b1;
    @(negedge SYSCLK);
    START = 1'b0;
    n0 = cyc;
  endtask

  task automatic check_dv(input string tag, input int idx, input int exp_cyc, input logic [DB-1:0] exp_dat);
    if (dv_cyc_q.size() > idx) begin
      check({tag, "_lat"}, dv_cyc_q[idx], exp_cyc);
      check({tag, "_data"}, dv_dat_q[idx], exp_dat);
    end
  endtask

  task automatic single_conv(input logic [DB-1:0] pat, input string tag);
    int n0, b_cnv, b_sclk;
    b_cnv  = n_cnv;
    b_sclk = n_sclk;
    dv_cyc_q.delete();
    dv_dat_q.delete();
    pat_q.push_back(pat);
    pulse_start(n0);
    check({tag, "_busy_on"}, BUSY, 1);
    check({tag, "_cnvst_on"}, AD_CNVST, 1);
    repeat (LAT + 8) @(negedge SYSCLK);
    check({tag, "_dv_count"}, dv_cyc_q.size(), 1);
    check_dv(tag, 0, n0 + LAT, pat);
    check({tag, "_cnvst_rises"}, n_cnv - b_cnv, 1);
    check({tag, "_cnvst_width"}, last_run, CNVH);
    check({tag, "_sclk_rises"}, n_sclk - b_sclk, DB);
    check({tag, "_busy_off"}, BUSY, 0);
    check({tag, "_data_hold"}, DATA, pat);
  endtask

  initial begin
    int            n0, b_cnv;
    logic [DB-1:0] pats[3];

    RESET = 1'b1;
    START = 1'b0;
    CONT  = 1'b0;
    repeat (3) @(negedge SYSCLK);
    check("rst_cnvst", AD_CNVST, 0);
    check("rst_sclk", AD_SCLK, 0);
    check("rst_data", DATA, 0);
    check("rst_dv", DATA_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    RESET = 1'b0;

    // First START after reset, known pattern.
    single_conv(16'hABCD, "single");

    for (int i = 0; i < 4; i++) single_conv(16'($urandom), "rand");

    // Continuous mode, CONT dropped during the third READ.
    pats[0] = 16'h0000;
    pats[1] = 16'hFFFF;
    pats[2] = 16'($urandom);
    for (int i = 0; i < 3; i++) pat_q.push_back(pats[i]);
    dv_cyc_q.delete();
    dv_dat_q.delete();
    b_cnv = n_cnv;
    @(negedge SYSCLK);
    CONT = 1'b1;
    @(negedge SYSCLK);
    n0 = cyc;
    repeat (2 * LAT + CNVH + 20) @(negedge SYSCLK);
    CONT = 1'b0;
    repeat (LAT + 20) @(negedge SYSCLK);
    check("cont_dv_count", dv_cyc_q.size(), 3);
    for (int i = 0; i < 3; i++) check_dv("cont", i, n0 + (i + 1) * LAT, pats[i]);
    check("cont_cnvst_rises", n_cnv - b_cnv, 3);
    check("cont_busy_off", BUSY, 0);

    // START re-pulsed at cycle 50 of a conversion must be dropped.
    dv_cyc_q.delete();
    dv_dat_q.delete();
    b_cnv = n_cnv;
    pats[0] = 16'($urandom);
    pat_q.push_back(pats[0]);
    pulse_start(n0);
    repeat (49) @(negedge SYSCLK);
    START = 1'b1;
    @(negedge SYSCLK);
    START = 1'b0;
    repeat (2 * LAT) @(negedge SYSCLK);
    check("ign_dv_count", dv_cyc_q.size(), 1);
    check_dv("ign", 0, n0 + LAT, pats[0]);
    check("ign_cnvst_rises", n_cnv - b_cnv, 1);
    check("ign_busy_off", BUSY, 0);

    // Reset pulse after bit 7 of READ.
    dv_cyc_q.delete();
    dv_dat_q.delete();
    pat_q.push_back(16'($urandom));
    pulse_start(n0);
    repeat (CNVH + 4 * 8 + 1) @(negedge SYSCLK);
    hold_chk_en = 1'b0;
    #1 RESET = 1'b1;
    #1;
    check("mid_rst_cnvst", AD_CNVST, 0);
    check("mid_rst_sclk", AD_SCLK, 0);
    check("mid_rst_data", DATA, 0);
    check("mid_rst_dv", DATA_VALID, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_err", ERR, 0);
    #1 RESET = 1'b0;
    repeat (LAT) @(negedge SYSCLK);
    check("mid_rst_no_dv", dv_cyc_q.size(), 0);
    hold_chk_en = 1'b1;
    single_conv(16'($urandom), "post_rst");

    check("dv_single_pulse", n_dv_long, 0);
    check("data_hold_between", hold_err, 0);
    check("err_idle", ERR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ads8864_ctrl.md
ADS8864_CTRL -- requirements
Module: ads8864_ctrl

Interface -- parameters
REQ-001 SHALL provide parameter SCLK_DIV, default 2: number of SYSCLK cycles in each AD_SCLK phase (low and high), giving 25 MHz at 100 MHz SYSCLK.
REQ-002 SHALL provide parameter CNV_HIGH, default 140: number of SYSCLK cycles AD_CNVST is held high (1400 ns).
REQ-003 SHALL provide parameter DATA_BITS, default 16: number of bits shifted per conversion.
REQ-004 SHALL provide parameter BUSY_TIMEOUT, default 200: maximum number of SYSCLK cycles spent waiting for busy-low (only used when ADS8864_BUSY_IND_EN is defined).

Interface -- ports
REQ-005 SHALL provide SYSCLK  in  1  the single 100 MHz clock; all logic is on its rising edge.
REQ-006 SHALL provide RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL provide START  in  1  conversion request; sampled only in IDLE.
REQ-008 SHALL provide CONT  in  1  continuous mode; restarts a conversion after DONE while held high.
REQ-009 SHALL provide AD_CNVST  out  1  ADC convert-start, registered.
REQ-010 SHALL provide AD_SCLK  out  1  ADC serial clock, registered, idle low.
REQ-011 SHALL provide AD_SDOUT  in  1  ADC serial data, MSB first.
REQ-012 SHALL provide DATA  out  DATA_BITS  last captured sample.
REQ-013 SHALL provide DATA_VALID  out  1  one-cycle pulse when DATA is updated.
REQ-014 SHALL provide BUSY  out  1  high whenever the state is not IDLE.
REQ-015 SHALL provide ERR  out  1  one-cycle pulse on busy timeout.

Function
REQ-016 SHALL implement the states IDLE, CONV, READ and DONE.
REQ-017 IDLE SHALL drive AD_CNVST=0 and AD_SCLK=0, and SHALL go to CONV when START or CONT is sampled high.
REQ-018 CONV SHALL drive AD_CNVST=1 for exactly CNV_HIGH cycles, then go to READ with AD_CNVST=0 in the first READ cycle.
REQ-019 READ SHALL emit exactly DATA_BITS AD_SCLK pulses, each SCLK_DIV cycles low followed by SCLK_DIV cycles high.
REQ-020 READ SHALL sample AD_SDOUT on the SYSCLK edge that ends each high phase and shift it into a DATA_BITS shift register, left-shift with MSB first.
REQ-021 After the last bit, READ SHALL go to DONE; DONE SHALL last 1 cycle, load DATA from the shift register, and pulse DATA_VALID.
REQ-022 DONE SHALL go to CONV if CONT=1, otherwise to IDLE.
REQ-023 Latency SHALL be 1+CNV_HIGH+2*SCLK_DIV*DATA_BITS cycles from the START-sampled edge to DATA_VALID (205 cycles with default parameters); the continuous-mode period SHALL be the same value.
REQ-024 START while BUSY=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 CONT falling mid-conversion SHALL let the current conversion complete, then go to IDLE.
REQ-026 DATA SHALL hold its value between DONE cycles.
REQ-027 Phase and bit counters SHALL clear on every entry to CONV and SHALL never wrap within a conversion.

Reset
REQ-028 RESET asserted SHALL immediately force IDLE, AD_CNVST=0, AD_SCLK=0, DATA=0, DATA_VALID=0, BUSY=0, ERR=0 and all counters to 0, including when asserted mid-operation.
REQ-029 The first START after RESET deassertion SHALL be honoured on the next edge.

Configuration
REQ-030 When ADS8864_BUSY_IND_EN is defined, CONV SHALL end on the first cycle in which AD_SDOUT, after a 2-flop synchronizer, reads 0.
REQ-031 When ADS8864_BUSY_IND_EN is defined, AD_CNVST SHALL stay high until that cycle, and CNV_HIGH SHALL be unused.
REQ-032 When ADS8864_BUSY_IND_EN is defined and busy-low is not seen within BUSY_TIMEOUT cycles of entering CONV, the block SHALL pulse ERR, drop AD_CNVST, go to IDLE, and SHALL NOT pulse DATA_VALID.
REQ-033 When ADS8864_BUSY_IND_EN is undefined, the block SHALL use fixed CNV_HIGH timing, ERR SHALL be tied to 0, and no synchronizer SHALL be built.

Structure
REQ-034 Package ads8864_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-035 Sub-module ads8864_sclk_gen SHALL generate AD_SCLK and a one-cycle sample strobe from SCLK_DIV, enabled only in READ.

Verification
REQ-036 Single conversion: START pulse with AD_SDOUT pattern 0xABCD -> AD_CNVST high 140 cycles, 16 AD_SCLK rising edges, DATA=0xABCD, DATA_VALID single pulse 205 cycles after START.
REQ-037 Continuous mode: CONT=1 with patterns 0x0000 then 0xFFFF -> DATA_VALID pulses 205 cycles apart with DATA 0x0000 then 0xFFFF; CONT dropped mid-READ -> one more DATA_VALID, then BUSY=0.
REQ-038 Ignored START: START re-pulsed at cycle 50 of a conversion -> exactly one DATA_VALID and no extra AD_CNVST pulse.
REQ-039 Reset mid-READ: RESET pulse after bit 7 -> all outputs 0 on the same cycle, no DATA_VALID, and the next START yields a correct sample.
REQ-040 With ADS8864_BUSY_IND_EN: AD_SDOUT low 80 cycles after AD_CNVST rises -> READ starts within 3 cycles.
REQ-041 With ADS8864_BUSY_IND_EN: AD_SDOUT held high -> ERR pulse at cycle 200 of CONV, then IDLE with no DATA_VALID.
